// File: rtl/odd_qw_shift_pipe_pkg.sv
// ----------------------------------------------------------------------------
// Package: descriptions
// Purpose: Shared types for the odd-pipe quadword shift/rotate unit.
//          - opcode_t : odd-pipe opcode encoding. The eight shift/rotate ops
//                       are supported here. A few other odd-pipe ops are listed
//                       so that upstream logic can issue them, and so that the
//                       illegal-op path can be exercised.
//          - QW_BYTES : bytes per architectural quadword.
//          - qword_t  : big-endian quadword, bit 0 = MSB.
//          - uses_immediate() : true for ops that take their count from I7.
// Ports:   none (package).
// ----------------------------------------------------------------------------
package descriptions;

    localparam int QW_BYTES = 16;

    typedef logic [0:127] qword_t;

    typedef enum logic [7:0] {
        SHIFT_LEFT_QUADWORD_BY_BITS            = 8'h00,
        SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE  = 8'h01,
        ROTATE_QUADWORD_BY_BITS                = 8'h02,
        ROTATE_QUADWORD_BY_BITS_IMMEDIATE      = 8'h03,
        SHIFT_LEFT_QUADWORD_BY_BYTES           = 8'h04,
        SHIFT_LEFT_QUADWORD_BY_BYTES_IMMEDIATE = 8'h05,
        ROTATE_QUADWORD_BY_BYTES               = 8'h06,
        ROTATE_QUADWORD_BY_BYTES_IMMEDIATE     = 8'h07,
        ADD_WORD                               = 8'h10,
        AND_WORD                               = 8'h11,
        NOP_ODD                                = 8'hFF
    } opcode_t;

    // Immediate forms take their count from I7 rather than rb's preferred slot.
    function automatic logic uses_immediate(input opcode_t op);
        return op inside {SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE,
                          ROTATE_QUADWORD_BY_BITS_IMMEDIATE,
                          SHIFT_LEFT_QUADWORD_BY_BYTES_IMMEDIATE,
                          ROTATE_QUADWORD_BY_BYTES_IMMEDIATE};
    endfunction

endpackage : descriptions

// File: rtl/odd_qw_shift_pipe_core.sv
// ----------------------------------------------------------------------------
// Module: qw_shift_core
// Purpose: Combinational quadword shift/rotate datapath for stage 1 of the
//          odd pipe. Operand bit 0 is the MSB. "Left" moves bits toward bit 0.
//          - Bit ops use count mod 8. Shift zero-fills from the LSB end.
//          - Byte ops use the full 5-bit count. Shift by >= DATA_W/8 bytes
//            yields zero. Rotate uses count mod DATA_W/8.
//          - Any other opcode gives result 0 and legal = 0.
// Parameters:
//   DATA_W  operand width, multiple of 8
// Ports:
//   op      in   opcode_t     operation
//   ra      in   DATA_W       source quadword
//   count   in   5            shift count, already selected from rb or I7
//   result  out  DATA_W       shifted / rotated quadword
//   legal   out  1            op is one of the supported shift/rotate ops
// ----------------------------------------------------------------------------
module qw_shift_core
    import descriptions::*;
#(
    parameter int DATA_W = 128
) (
    input  opcode_t             op,
    input  logic [0:DATA_W-1]   ra,
    input  logic [4:0]          count,
    output logic [0:DATA_W-1]   result,
    output logic                legal
);

    localparam int unsigned BYTES = DATA_W / 8;

    int unsigned bit_sh;
    int unsigned byte_cnt;
    int unsigned byte_sh;
    int unsigned rot_byte_sh;

    // NOTE: every variable written in this always_comb gets a value before the
    // case statement, so no path can leave one unassigned and infer a latch.
    always_comb begin
        bit_sh      = 32'(count[2:0]);
        byte_cnt    = 32'(count);
        byte_sh     = byte_cnt * 8;
        rot_byte_sh = (byte_cnt % BYTES) * 8;
        result      = '0;
        legal       = 1'b1;

        case (op)
            SHIFT_LEFT_QUADWORD_BY_BITS,
            SHIFT_LEFT_QUADWORD_BY_BITS_IMMEDIATE: begin
                result = ra << bit_sh;
            end
            ROTATE_QUADWORD_BY_BITS,
            ROTATE_QUADWORD_BY_BITS_IMMEDIATE: begin
                // A right shift by the full width yields zero, so a
                // count of 0 correctly returns ra unchanged.
                result = (ra << bit_sh) | (ra >> (DATA_W - bit_sh));
            end
            SHIFT_LEFT_QUADWORD_BY_BYTES,
            SHIFT_LEFT_QUADWORD_BY_BYTES_IMMEDIATE: begin
                if (byte_cnt >= BYTES) begin
                    result = '0;
                end else begin
                    result = ra << byte_sh;
                end
            end
            ROTATE_QUADWORD_BY_BYTES,
            ROTATE_QUADWORD_BY_BYTES_IMMEDIATE: begin
                result = (ra << rot_byte_sh) | (ra >> (DATA_W - rot_byte_sh));
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule : qw_shift_core

// File: rtl/odd_qw_shift_pipe.sv
// ----------------------------------------------------------------------------
// Module: odd_qw_shift_pipe
// Purpose: Odd-pipe quadword shift/rotate unit. It accepts one op per cycle.
//          The result is computed combinationally in stage 1. Stages 2..LATENCY
//          are pure delay. The last stage drives the outputs, so an op issued
//          at one edge is visible LATENCY cycles later.
//          It supports stall (freeze everything), flush (kill in-flight ops and
//          the same-cycle issue), and illegal-op reporting.
// Optional feature macro: ODD_FWD_TAPS_EN. When it is defined, the unit adds
//          per-stage forwarding taps.
// Parameters:
//   DATA_W   quadword width (multiple of 8, >= 32)
//   ADDR_W   register address width
//   LATENCY  pipeline register stages (>= 1)
// Ports:
//   clock               in   1        rising-edge clock
//   reset               in   1        synchronous, active-high
//   op_input_op_code    in   opcode_t operation
//   valid_input         in   1        issue strobe
//   stall_input         in   1        freeze all stages; issue ignored
//   flush_input         in   1        kill in-flight ops and same-cycle issue
//   ra_input            in   DATA_W   source quadword
//   rb_input            in   DATA_W   count source, preferred slot rb[0:31]
//   I7_input            in   7        immediate count
//   rt_address_input    in   ADDR_W   destination register
//   rt_value_output     out  DATA_W   result
//   rt_address_output   out  ADDR_W   destination register
//   wrt_en_output       out  1        write-back strobe (held while stalled)
//   illegal_op_output   out  1        strobe in place of wrt_en for bad opcode
//   fwd_valid_output    out  [LATENCY]          (ODD_FWD_TAPS_EN) stage valid
//   fwd_addr_output     out  [LATENCY][ADDR_W]  (ODD_FWD_TAPS_EN) stage address
//   fwd_value_output    out  [LATENCY][DATA_W]  (ODD_FWD_TAPS_EN) stage result
// ----------------------------------------------------------------------------
module odd_qw_shift_pipe
    import descriptions::*;
#(
    parameter int DATA_W  = 128,
    parameter int ADDR_W  = 7,
    parameter int LATENCY = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  opcode_t             op_input_op_code,
    input  logic                valid_input,
    input  logic                stall_input,
    input  logic                flush_input,
    input  logic [0:DATA_W-1]   ra_input,
    input  logic [0:DATA_W-1]   rb_input,
    input  logic [6:0]          I7_input,
    input  logic [ADDR_W-1:0]   rt_address_input,
    output logic [0:DATA_W-1]   rt_value_output,
    output logic [ADDR_W-1:0]   rt_address_output,
    output logic                wrt_en_output,
    output logic                illegal_op_output
`ifdef ODD_FWD_TAPS_EN
    ,
    output logic                fwd_valid_output [LATENCY],
    output logic [ADDR_W-1:0]   fwd_addr_output  [LATENCY],
    output logic [0:DATA_W-1]   fwd_value_output [LATENCY]
`endif
);

    // ------------------------------------------------------------------
    // Stage 1 combinational datapath
    // ------------------------------------------------------------------
    logic [4:0]         count;
    logic [0:DATA_W-1]  core_result;
    logic               core_legal;
    logic               issue;

    // Bit ops only look at the low three bits. rb[27:31] therefore also
    // carries the rb[29:31] bit count.
    assign count = uses_immediate(op_input_op_code) ? I7_input[4:0] : rb_input[27:31];
    assign issue = valid_input & ~stall_input & ~flush_input;

    // Bits of rb outside the count field, and the top of I7, are never used
    // by these ops.
    logic unused_bits;
    assign unused_bits = ^{rb_input[0:26], rb_input[32:DATA_W-1], I7_input[6:5]};

    qw_shift_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .op     (op_input_op_code),
        .ra     (ra_input),
        .count  (count),
        .result (core_result),
        .legal  (core_legal)
    );

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic               stg_valid   [LATENCY];
    logic               stg_illegal [LATENCY];
    logic [ADDR_W-1:0]  stg_addr    [LATENCY];
    logic [0:DATA_W-1]  stg_value   [LATENCY];

    for (genvar g = 0; g < LATENCY; g++) begin : gen_stage
        logic               d_valid;
        logic               d_illegal;
        logic [ADDR_W-1:0]  d_addr;
        logic [0:DATA_W-1]  d_value;

        if (g == 0) begin : gen_head
            assign d_valid   = issue;
            assign d_illegal = ~core_legal;
            assign d_addr    = rt_address_input;
            assign d_value   = core_result;
        end else begin : gen_body
            assign d_valid   = stg_valid[g-1];
            assign d_illegal = stg_illegal[g-1];
            assign d_addr    = stg_addr[g-1];
            assign d_value   = stg_value[g-1];
        end

        // NOTE: state is updated with non-blocking assignments so that every
        // stage samples its predecessor's pre-edge value. Blocking assignments
        // here would let one op ripple through several stages in one edge.
        // NOTE: address/value are reset along with the valids because the
        // last stage drives the outputs directly, and all outputs must read 0
        // after reset. Flush clears only the valids.
        always_ff @(posedge clock) begin
            if (reset) begin
                stg_valid[g]   <= 1'b0;
                stg_illegal[g] <= 1'b0;
                stg_addr[g]    <= '0;
                stg_value[g]   <= '0;
            end else begin
                if (flush_input) begin
                    stg_valid[g] <= 1'b0;
                end else if (!stall_input) begin
                    stg_valid[g] <= d_valid;
                end
                if (!stall_input) begin
                    stg_illegal[g] <= d_illegal;
                    stg_addr[g]    <= d_addr;
                    stg_value[g]   <= d_value;
                end
            end
        end

`ifdef ODD_FWD_TAPS_EN
        // Illegal ops never write back, so they are not offered for forwarding.
        assign fwd_valid_output[g] = stg_valid[g] & ~stg_illegal[g];
        assign fwd_addr_output[g]  = stg_addr[g];
        assign fwd_value_output[g] = stg_value[g];
`endif
    end : gen_stage

    // ------------------------------------------------------------------
    // Outputs come straight from the last stage register
    // ------------------------------------------------------------------
    assign rt_value_output   = stg_value[LATENCY-1];
    assign rt_address_output = stg_addr[LATENCY-1];
    assign wrt_en_output     = stg_valid[LATENCY-1] & ~stg_illegal[LATENCY-1];
    assign illegal_op_output = stg_valid[LATENCY-1] &  stg_illegal[LATENCY-1];

endmodule : odd_qw_shift_pipe
